instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 22, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 32, program memory entries.
REQ-003 SHALL have parameter PTR_W, default 5, address width, ceil(log2(DEPTH)).
REQ-004 SHALL have parameter DEB_CYCLES, default 50000, cycles a button must be stable to register.
REQ-005 SHALL have parameter WRAP, default 1; 1 = restart at 0 after last entry, 0 = halt.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 step_btn_n  in  1  raw active-low step button, asynchronous.
REQ-009 mode_auto  in  1  0 = single-step, 1 = auto-run; synchronised internally.
REQ-010 prog_len  in  PTR_W+1  number of valid entries, 1..DEPTH.
REQ-011 ld_en, ld_addr[PTR_W], ld_data[INSTR_W]  in  program write port.
REQ-012 instr  out  INSTR_W  instruction to coprocessor.
REQ-013 instr_valid  out  1  instr is valid; instr_ready  in  1  coprocessor accepts.
REQ-014 done  in  1  one-cycle pulse, coprocessor finished current instruction.
REQ-015 pc  out  PTR_W  current entry index; halted  out  1; busy  out  1.

Function
REQ-016 Button SHALL pass a 2-flop synchroniser, then a stability counter; a press registers after DEB_CYCLES consecutive stable-low cycles, giving one single-cycle step pulse per press.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_DONE, HALT.
REQ-018 IDLE: step pulse -> ISSUE; if mode_auto=1, step pulse also sets internal run flag.
REQ-019 ISSUE: instr = mem[pc], instr_valid=1, held stable until instr_valid && instr_ready; that cycle -> WAIT_DONE, instr_valid=0 next cycle.
REQ-020 WAIT_DONE: on done, pc advances; if pc == prog_len-1: WRAP=1 -> pc=0, WRAP=0 -> HALT (pc unchanged).
REQ-021 After done (not halting): run flag set -> ISSUE next cycle; else -> IDLE.
REQ-022 done outside WAIT_DONE SHALL be ignored.
REQ-023 Step pulse in ISSUE/WAIT_DONE SHALL clear the run flag (stop after current instruction); it SHALL not restart issue.
REQ-024 mode_auto falling SHALL clear run flag; sequencer finishes current instruction then IDLE.
REQ-025 HALT: halted=1; step pulse -> pc=0, halted=0, run flag cleared, IDLE.
REQ-026 ld_en SHALL write mem[ld_addr] only in IDLE or HALT; ignored otherwise; ld_addr >= DEPTH ignored.
REQ-027 Write to mem[pc] in IDLE SHALL be visible to the next ISSUE.
REQ-028 busy=1 in ISSUE and WAIT_DONE, else 0.
REQ-029 prog_len of 0 or > DEPTH SHALL be treated as DEPTH.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, pc=0, instr=0, instr_valid=0, halted=0, busy=0, run flag=0, debounce counter and synchroniser to released state.
REQ-031 Program memory SHALL not be reset; contents hold across reset.
REQ-032 Reset mid-ISSUE SHALL drop instr_valid without handshake completion.

Structure
REQ-033 FSM state encoding and the STATE_W constant SHALL live in the shared coprocessor package.
REQ-034 Debounce plus edge pulse SHALL be one sub-module, btn_pulse, parameterised by DEB_CYCLES.
REQ-035 Program memory SHALL be a synchronous-write register array inferable as RAM.

Verification (DEB_CYCLES=4, DEPTH=8, prog_len=3)
REQ-036 Load 0x000011,0x000022,0x000033; press step 3x, ready=1, done 2 cycles after accept -> instr 0x000011, 0x000022, 0x000033 in order, pc 0->1->2->0 (WRAP=1).
REQ-037 Button bounce low for 2 cycles then high -> no step pulse; held low 4+ cycles -> exactly one pulse.
REQ-038 mode_auto=1, one press, ready low 5 cycles on first issue -> instr_valid and instr stable 5 cycles; all 3 issued without further presses.
REQ-039 WRAP=0, auto-run -> after third done halted=1, pc=2; press -> pc=0, halted=0, IDLE.
REQ-040 ld_en during WAIT_DONE to addr 1 -> mem[1] unchanged; done pulse in IDLE -> pc unchanged.
REQ-041 rst_n low during ISSUE -> instr_valid=0, pc=0 same cycle asynchronously; memory retains loaded program.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding.
package instr_sequencer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StHalt
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Valid/ready instruction channel from the sequencer to the coprocessor, plus its done pulse.
interface instr_sequencer_if #(
  parameter int unsigned INSTR_W = 22
) ();

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               done;

  modport master (output instr, output instr_valid, input instr_ready, input done);
  modport slave  (input instr, input instr_valid, output instr_ready, output done);

endinterface

// File: rtl/instr_sequencer_btn_pulse.sv
// Debounces a raw active-low button and emits one single-cycle pulse per registered press.
module btn_pulse #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            fired_q, fired_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      fired_q <= fired_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any high sample restarts the stability window; fired_q blocks repeats until release.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    pulse_d = 1'b0;
    if (sync2_q) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (!fired_q) begin
      if (cnt_q == CntMax) begin
        pulse_d = 1'b1;
        fired_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/instr_sequencer.sv
// Steps through a small program memory, issuing one instruction per step (or auto-run) to a
// coprocessor over a valid/ready channel and waiting for its done pulse.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned INSTR_W    = 22,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned PTR_W      = 5,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned WRAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_btn_n,
  input  logic                 mode_auto,
  input  logic [PTR_W:0]       prog_len,
  input  logic                 ld_en,
  input  logic [PTR_W-1:0]     ld_addr,
  input  logic [INSTR_W-1:0]   ld_data,
  instr_sequencer_if.master    bus,
  output logic [PTR_W-1:0]     pc,
  output logic                 halted,
  output logic                 busy
);

  localparam int unsigned LenW = PTR_W + 1;

  logic               step_pulse;
  logic               mode_sync_q, mode_q;
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   pc_q, pc_d;
  logic               run_q, run_d;
  logic [LenW-1:0]    last_idx;
  logic               at_last;
  logic               mem_wr;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  btn_pulse #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n_i(step_btn_n),
    .pulse_o(step_pulse)
  );

  // Out-of-range lengths fall back to the full memory.
  always_comb begin
    if (prog_len == '0 || prog_len > LenW'(DEPTH)) begin
      last_idx = LenW'(DEPTH - 1);
    end else begin
      last_idx = prog_len - LenW'(1);
    end
  end

  assign at_last = ({1'b0, pc_q} == last_idx);
  assign mem_wr  = ld_en && (state_q == StIdle || state_q == StHalt) && (32'(ld_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= 1'b0;
      mode_q      <= 1'b0;
      state_q     <= StIdle;
      pc_q        <= '0;
      run_q       <= 1'b0;
    end else begin
      mode_sync_q <= mode_auto;
      mode_q      <= mode_sync_q;
      state_q     <= state_d;
      pc_q        <= pc_d;
      run_q       <= run_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    run_d           = run_q;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    // Leaving auto mode lets the in-flight instruction finish, then parks in idle.
    if (!mode_q) begin
      run_d = 1'b0;
    end
    case (state_q)
      StIdle: begin
        if (step_pulse) begin
          state_d = StIssue;
          run_d   = mode_q;
        end
      end
      StIssue: begin
        bus.instr_valid = 1'b1;
        bus.instr       = mem_q[pc_q];
        if (step_pulse) begin
          run_d = 1'b0;
        end
        if (bus.instr_ready) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (step_pulse) begin
          run_d = 1'b0;
        end
        if (bus.done) begin
          if (at_last && WRAP == 0) begin
            state_d = StHalt;
            run_d   = 1'b0;
          end else begin
            pc_d    = at_last ? '0 : pc_q + PTR_W'(1);
            state_d = run_d ? StIssue : StIdle;
          end
        end
      end
      StHalt: begin
        if (step_pulse) begin
          pc_d    = '0;
          run_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc     = pc_q;
  assign halted = (state_q == StHalt);
  assign busy   = (state_q == StIssue) || (state_q == StWaitDone);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: two sequencers (wrapping and halting) against a program-level reference model.
module tb_instr_sequencer;

  localparam int unsigned IW    = 22;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;
  localparam int unsigned DEB   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, btn_a, btn_b, mode_a, mode_b, ld_en;
  logic [PW:0]   prog_len;
  logic [PW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic [PW-1:0] pc_a, pc_b;
  logic          halted_a, halted_b, busy_a, busy_b;
  logic          ready_a, ready_b, done_a, done_b, fdone_a;
  int            dly_a;

  instr_sequencer_if #(.INSTR_W(IW)) ifa ();
  instr_sequencer_if #(.INSTR_W(IW)) ifb ();

  assign ifa.instr_ready = ready_a;
  assign ifa.done        = done_a | fdone_a;
  assign ifb.instr_ready = ready_b;
  assign ifb.done        = done_b;

  instr_sequencer #(
    .INSTR_W(IW), .DEPTH(DEPTH), .PTR_W(PW), .DEB_CYCLES(DEB), .WRAP(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .step_btn_n(btn_a), .mode_auto(mode_a), .prog_len(prog_len),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .bus(ifa), .pc(pc_a),
    .halted(halted_a), .busy(busy_a)
  );

  instr_sequencer #(
    .INSTR_W(IW), .DEPTH(DEPTH), .PTR_W(PW), .DEB_CYCLES(DEB), .WRAP(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .step_btn_n(btn_b), .mode_auto(mode_b), .prog_len(prog_len),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .bus(ifb), .pc(pc_b),
    .halted(halted_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } exp_t;

  exp_t          q_a[$], q_b[$];
  logic [IW-1:0] mem_a[DEPTH], mem_b[DEPTH];
  int            pcm_a = 0, pcm_b = 0;
  int            n_checks = 0, n_err = 0;
  int            pulse_cnt = 0;

  always @(posedge clk) if (dut_a.step_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_len();
    int pl = int'(prog_len);
    if (pl == 0 || pl > int'(DEPTH)) return int'(DEPTH);
    return pl;
  endfunction

  // Coprocessor models: done pulses a fixed number of cycles after each accept.
  initial begin
    int dcnt = 0;
    done_a = 1'b0;
    forever begin
      @(negedge clk); #1;
      done_a = 1'b0;
      if (!rst_n) dcnt = 0;
      else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) done_a = 1'b1;
        end
        if (ifa.instr_valid && ready_a) dcnt = dly_a;
      end
    end
  end

  initial begin
    int dcnt = 0;
    done_b = 1'b0;
    forever begin
      @(negedge clk); #1;
      done_b = 1'b0;
      if (!rst_n) dcnt = 0;
      else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) done_b = 1'b1;
        end
        if (ifb.instr_valid && ready_b) dcnt = 2;
      end
    end
  end

  // Monitors: every accepted instruction must match the head of its expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && ifa.instr_valid && ready_a) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL a_unexpected_issue: got instr 0x%0h pc %0d, expected no issue",
                   ifa.instr, pc_a);
        end else begin
          e = q_a.pop_front();
          check("a_instr", 32'(ifa.instr), 32'(e.instr));
          check("a_issue_pc", 32'(pc_a), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && ifb.instr_valid && ready_b) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL b_unexpected_issue: got instr 0x%0h pc %0d, expected no issue",
                   ifb.instr, pc_b);
        end else begin
          e = q_b.pop_front();
          check("b_instr", 32'(ifb.instr), 32'(e.instr));
          check("b_issue_pc", 32'(pc_b), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic press(input bit sel, input int low);
    @(negedge clk);
    if (sel) btn_b = 1'b0;
    else btn_a = 1'b0;
    repeat (low) @(negedge clk);
    btn_a = 1'b1;
    btn_b = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data, input bit upd_a);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = PW'(addr);
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    if (upd_a) mem_a[addr] = data;
    mem_b[addr] = data;
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 200 && q_a.size() != 0; i++) @(negedge clk);
    for (int i = 0; i < 200 && busy_a; i++) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("a_back_to_idle", 32'(busy_a), 32'd0);
  endtask

  task automatic step_a();
    q_a.push_back('{instr: mem_a[pcm_a], pc: PW'(pcm_a)});
    pcm_a = (pcm_a + 1) % eff_len();
    press(1'b0, 8);
    wait_idle_a();
    check("a_pc_after_step", 32'(pc_a), 32'(pcm_a));
  endtask

  initial begin
    int p0;
    btn_a = 1'b1; btn_b = 1'b1; mode_a = 1'b0; mode_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; fdone_a = 1'b0; dly_a = 2;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; prog_len = 4'd3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc_a), 32'd0);
    check("rst_valid", 32'(ifa.instr_valid), 32'd0);
    check("rst_instr", 32'(ifa.instr), 32'd0);
    check("rst_halted", 32'(halted_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;

    load(0, 22'h000011, 1'b1);
    load(1, 22'h000022, 1'b1);
    load(2, 22'h000033, 1'b1);
    repeat (3) step_a();

    // Short bounce must not register; a long hold registers exactly once.
    p0 = pulse_cnt;
    @(negedge clk); btn_a = 1'b0;
    repeat (2) @(negedge clk);
    btn_a = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("bounce_no_issue", 32'(busy_a), 32'd0);
    step_a();
    check("hold_one_pulse", 32'(pulse_cnt - p0), 32'd1);

    // Load attempt while waiting for done is dropped; done in idle is ignored.
    dly_a = 10;
    q_a.push_back('{instr: mem_a[pcm_a], pc: PW'(pcm_a)});
    pcm_a = (pcm_a + 1) % eff_len();
    press(1'b0, 8);
    check("in_wait_done", 32'({busy_a, ifa.instr_valid}), 32'b10);
    load(1, IW'($urandom), 1'b0);
    wait_idle_a();
    dly_a = 2;
    @(negedge clk); fdone_a = 1'b1;
    @(negedge clk); fdone_a = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_pc", 32'(pc_a), 32'(pcm_a));
    check("idle_done_busy", 32'(busy_a), 32'd0);
    repeat (3) step_a();

    // Overwrite the entry at the current pc while idle.
    load(pcm_a, IW'($urandom), 1'b1);
    step_a();

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, DEPTH - 1)), IW'($urandom), 1'b1);
      else step_a();
    end

    // Auto-run stopped by dropping mode_auto while the first instruction is issued.
    mode_a = 1'b1;
    q_a.push_back('{instr: mem_a[pcm_a], pc: PW'(pcm_a)});
    pcm_a = (pcm_a + 1) % eff_len();
    @(negedge clk); btn_a = 1'b0;
    for (int i = 0; i < 50 && !ifa.instr_valid; i++) @(negedge clk);
    mode_a = 1'b0;
    btn_a = 1'b1;
    wait_idle_a();
    repeat (10) @(negedge clk);
    check("mode_fall_pc", 32'(pc_a), 32'(pcm_a));
    check("mode_fall_idle", 32'(busy_a), 32'd0);

    // prog_len of zero means the whole memory.
    prog_len = '0;
    for (int i = 0; i < int'(DEPTH); i++) load(i, IW'($urandom), 1'b1);
    repeat (9) step_a();
    if (pcm_a == 0) step_a();

    // Reset in the middle of an issue.
    ready_a = 1'b0;
    press(1'b0, 8);
    for (int i = 0; i < 50 && !ifa.instr_valid; i++) @(negedge clk);
    check("stalled_valid", 32'(ifa.instr_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ifa.instr_valid), 32'd0);
    check("async_rst_pc", 32'(pc_a), 32'd0);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    prog_len = 4'd3;
    ready_a = 1'b1;
    pcm_a = 0;
    @(negedge clk); rst_n = 1'b1;
    step_a();

    // Halting instance: auto-run with an initial stall, then halt and restart.
    for (int i = 0; i < 3; i++) load(i, IW'($urandom), 1'b1);
    mode_b = 1'b1;
    ready_b = 1'b0;
    for (int i = 0; i < 3; i++) q_b.push_back('{instr: mem_b[i], pc: PW'(i)});
    press(1'b1, 8);
    for (int i = 0; i < 50 && !ifb.instr_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(ifb.instr_valid), 32'd1);
      check("stall_instr", 32'(ifb.instr), 32'(mem_b[0]));
    end
    ready_b = 1'b1;
    for (int i = 0; i < 200 && !halted_b; i++) @(negedge clk);
    check("halt_flag", 32'(halted_b), 32'd1);
    check("halt_pc", 32'(pc_b), 32'd2);
    check("halt_busy", 32'(busy_b), 32'd0);
    check("halt_all_issued", 32'(q_b.size()), 32'd0);
    press(1'b1, 8);
    repeat (10) @(negedge clk);
    check("unhalt_flag", 32'(halted_b), 32'd0);
    check("unhalt_pc", 32'(pc_b), 32'd0);
    check("unhalt_idle", 32'(busy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
